// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order commit unit: 8-entry ROB with out-of-order writeback and precise exceptions
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_ack,
    output logic [2:0]        alloc_tag,
    input  logic              wb_valid,
    input  logic [2:0]        wb_tag,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [2:0]        wb_dest,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_pc,
    input  logic [1:0]        wb_ex_vector,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [2:0]        commit_addr,
    output logic [DATA_W-1:0] commit_data,
    output logic              exc_valid,
    output logic [DATA_W-1:0] exc_pc,
    output logic [1:0]        exc_cause,
    output logic [3:0]        count,
    output logic              full,
    output logic              empty
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH-1:0]  ent_alloc;
    logic [DEPTH-1:0]  ent_done;
    logic [DATA_W-1:0] ent_result [DEPTH];
    logic [2:0]        ent_dest   [DEPTH];
    logic              ent_we     [DEPTH];
    logic [DATA_W-1:0] ent_pc     [DEPTH];
    logic [1:0]        ent_ex     [DEPTH];

    logic [2:0] head;
    logic [2:0] tail;

    logic running;
    logic head_ready;
    logic exc_now;
    logic norm_commit;
    logic wb_accept;

    assign running     = (state_q == RUN);
    assign head_ready  = running & ent_alloc[head] & ent_done[head];
    assign exc_now     = head_ready & (ent_ex[head] != 2'b00);
    assign norm_commit = head_ready & (ent_ex[head] == 2'b00);

    // Grant looks at registered count only, so a same-cycle commit never frees a slot in a full ROB.
    assign alloc_ack = alloc_req & ~count[3] & running & ~exc_now;
    assign alloc_tag = tail;

    // A writeback to the slot being allocated this cycle belongs to a stale instruction.
    assign wb_accept = running & ~exc_now & wb_valid & ent_alloc[wb_tag] & ~ent_done[wb_tag]
                     & ~(alloc_ack & (wb_tag == tail));

    assign full  = (count == 4'd8);
    assign empty = (count == 4'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (exc_now) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_alloc <= '0;
            ent_done  <= '0;
            head      <= 3'd0;
            tail      <= 3'd0;
            count     <= 4'd0;
        end else if (exc_now) begin
            ent_alloc <= '0;
            ent_done  <= '0;
            head      <= 3'd0;
            tail      <= 3'd0;
            count     <= 4'd0;
        end else begin
            if (norm_commit) begin
                ent_alloc[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + 3'd1;
            end
            if (alloc_ack) begin
                ent_alloc[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + 3'd1;
            end
            if (wb_accept) begin
                ent_done[wb_tag] <= 1'b1;
            end
            count <= count + {3'b000, alloc_ack} - {3'b000, norm_commit};
        end
    end

    // Payload is qualified by alloc/done, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wb_accept) begin
            ent_result[wb_tag] <= wb_result;
            ent_dest[wb_tag]   <= wb_dest;
            ent_we[wb_tag]     <= wb_we;
            ent_pc[wb_tag]     <= wb_pc;
            ent_ex[wb_tag]     <= wb_ex_vector;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            commit_addr  <= 3'd0;
            commit_data  <= '0;
            exc_valid    <= 1'b0;
            exc_pc       <= '0;
            exc_cause    <= 2'b00;
        end else begin
            commit_valid <= norm_commit;
            commit_we    <= norm_commit & ent_we[head];
            commit_addr  <= norm_commit ? ent_dest[head] : 3'd0;
            commit_data  <= norm_commit ? ent_result[head] : '0;
            exc_valid    <= exc_now;
            exc_pc       <= exc_now ? ent_pc[head] : '0;
            exc_cause    <= exc_now ? ent_ex[head] : 2'b00;
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (!reset) count <= 4'd8);
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(norm_commit && count == 4'd0));
    a_ptr_consistent: assert property (@(posedge clk) disable iff (!reset)
        (head != tail) || (count == 4'd0) || (count == 4'd8));
    a_empty_quiet: assert property (@(posedge clk) disable iff (!reset) empty |=> !commit_valid);

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- In-order commit unit: the consumer end of the writeback pipeline register.
- Tracks up to 8 in-flight instructions by 3-bit ROB tag.
- Accepts out-of-order writebacks tagged with the tail_rob value.
- Retires results in program order to the register file, and raises a precise exception (pc, cause) when the head entry carries a non-zero exception vector.

Parameters:
DEPTH, 8, ROB entries (tag width log2(DEPTH)=3; only 8 supported)
DATA_W, 16, result/pc width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
alloc_req  in  1  decode requests a ROB entry
alloc_ack  out  1  combinational: entry granted this cycle
alloc_tag  out  3  combinational: current tail index (tag granted when alloc_ack=1)
wb_valid  in  1  writeback present (driven by ticketWE from the writeback register)
wb_tag  in  3  ROB tag of writeback (tail_rob)
wb_result  in  16  result value
wb_dest  in  3  destination register
wb_we  in  1  instruction writes register file
wb_pc  in  16  pc of instruction
wb_ex_vector  in  2  exception cause, 0 = none
commit_valid  out  1  registered: one instruction retired
commit_we  out  1  registered: register-file write enable
commit_addr  out  3  registered: register-file address
commit_data  out  16  registered: register-file data
exc_valid  out  1  registered: exception pulse
exc_pc  out  16  registered: faulting pc
exc_cause  out  2  registered: faulting ex_vector
count  out  4  registered occupancy 0..8
full  out  1  count==8
empty  out  1  count==0

Behaviour:
- Per-entry state: alloc (allocated), done (written back), plus result, dest, we, pc, ex.
- Pointers: head and tail are 3 bits and wrap 7->0. count is 4 bits.
- Reset (async, reset=0): head=tail=0, count=0, all alloc/done=0, every registered output=0, FSM=RUN.
- FSM states:
  - RUN: normal operation.
  - FLUSH: exactly one cycle, entered after an exception commit. In FLUSH: alloc_ack=0, writebacks ignored, no commit. FLUSH returns to RUN unconditionally.
- Allocation:
  - alloc_ack = alloc_req & (count<8) & (state==RUN) & ~exc_now.
  - exc_now = head entry alloc & done & ex!=0.
  - On ack at the clock edge: entry[tail] alloc=1, done=0; tail+1.
  - Grant uses registered count only. A commit in the same cycle does not free space for a full ROB.
- Writeback (RUN only):
  - If wb_valid and entry[wb_tag].alloc=1 and done=0: store result/dest/we/pc/ex and set done=1.
  - Writeback to an unallocated or already-done entry is dropped silently.
  - Writeback targeting the entry being allocated in the same cycle is dropped.
- Commit (RUN only; decided from registered head state; at most one per cycle):
  - Normal commit (head alloc & done & ex==0):
    - Next cycle: commit_valid=1, commit_we=we, commit_addr=dest, commit_data=result.
    - Clear alloc/done of the entry; head+1.
  - Exception commit (exc_now):
    - Next cycle: exc_valid=1, exc_pc=pc, exc_cause=ex, commit_valid=0, commit_we=0.
    - Clear all entries; head=tail=0, count=0; state<=FLUSH.
  - A writeback landing on the head entry this cycle commits no earlier than the next cycle (1-cycle minimum wb->commit decision; commit outputs visible 2 edges after wb).
  - commit_valid and exc_valid are single-cycle pulses; both are 0 whenever no commit occurs.
- Occupancy:
  - count next = count + ack − normal_commit (simultaneous alloc+commit holds count).
  - Exception forces count to 0 regardless of a same-cycle alloc, which is not acked by construction.
- Invariants (assert):
  - count never exceeds 8 or underflows.
  - head==tail implies count∈{0,8}.
  - Empty ROB: no commit; commit outputs held 0.

Test Plan:
- Reset mid-operation with count=5 → all outputs 0, empty=1, alloc_tag=0 immediately (async).
- Alloc tags 0,1,2; wb tag2 (r3=0x0033), tag0 (r1=0x0011), tag1 (r2=0x0022) → commits in order r1,r2,r3 with data 0x0011,0x0022,0x0033 on consecutive cycles, count 3→0.
- Alloc 8 → full=1; 9th alloc_req gets alloc_ack=0. Commit head while alloc_req held → ack only on the cycle after count drops to 7. Tail wraps 7→0.
- Alloc tags 0,1; wb tag1 normal, wb tag0 ex=2'b01, pc=0x0040 → exc_valid=1, exc_pc=0x0040, exc_cause=1, no commit of tag1, count=0. The following cycle alloc_ack=0 and a wb to tag1 is dropped.
- Duplicate wb to a done entry (second value 0xBEEF) and wb to an unallocated tag → ignored; the committed data is the first value.
- wb_we=0 instruction at head → commit_valid=1, commit_we=0.
